// File: rtl/io_bus_responder_pkg.sv
// Shared constants for the I/O responder: bus FSM states, register offsets and Steuer bit indices.
// Also holds the window decode helpers used by the responder.
package io_bus_responder_pkg;

    typedef enum logic [1:0] {
        LEERLAUF = 2'd0,
        WARTEN   = 2'd1,
        QUITTUNG = 2'd2,
        FREIGABE = 2'd3
    } busState_t;

    localparam logic [2:0] OFS_AUSGANG   = 3'd0;
    localparam logic [2:0] OFS_EINGANG   = 3'd1;
    localparam logic [2:0] OFS_ZAEHLER   = 3'd2;
    localparam logic [2:0] OFS_VERGLEICH = 3'd3;
    localparam logic [2:0] OFS_STEUER    = 3'd4;

    localparam int STEUER_ENABLE  = 0;
    localparam int STEUER_TREFFER = 1;
    localparam int STEUER_IRQ_EN  = 2;

    // Unsigned difference, so addresses below the base wrap high and fall outside the window.
    function automatic logic inWindow(input logic [31:0] adr, input logic [31:0] basis);
        logic [31:0] diff;
        diff = adr - basis;
        return diff < 32'd8;
    endfunction

    function automatic logic [2:0] wortOffset(input logic [31:0] adr, input logic [31:0] basis);
        logic [31:0] diff;
        diff = adr - basis;
        return diff[2:0];
    endfunction

endpackage

// File: rtl/io_bus_responder_if.sv
// CPU data-port handshake between an initiator (master) and the I/O responder (slave).
interface io_bus_responder_if;
    logic        LesenAn;
    logic        SchreibenAn;
    logic [31:0] Adresse;
    logic [31:0] DatenRein;
    logic [31:0] DatenRaus;
    logic        DatenBereit;
    logic        DatenGeschrieben;

    modport master (
        output LesenAn, SchreibenAn, Adresse, DatenRein,
        input  DatenRaus, DatenBereit, DatenGeschrieben
    );

    modport slave (
        input  LesenAn, SchreibenAn, Adresse, DatenRein,
        output DatenRaus, DatenBereit, DatenGeschrieben
    );
endinterface

// File: rtl/io_bus_responder_timer_einheit.sv
// Free-running timer with compare: Zaehler, Vergleich, Enable and the sticky Treffer flag.
// Register writes arrive as one-cycle strobes from the bus responder.
module timer_einheit
    import io_bus_responder_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        wrZaehler,
    input  logic        wrVergleich,
    input  logic        wrSteuer,
    input  logic [31:0] wrDaten,
    output logic [31:0] zaehler,
    output logic [31:0] vergleich,
    output logic        enable,
    output logic        treffer
);

    logic hit;

    assign hit = enable && (zaehler == vergleich);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zaehler   <= '0;
            vergleich <= '1;
            enable    <= 1'b0;
            treffer   <= 1'b0;
        end else begin
            if (wrZaehler)
                zaehler <= wrDaten;
            else if (enable)
                zaehler <= zaehler + 32'd1;
            if (wrVergleich)
                vergleich <= wrDaten;
            if (wrSteuer)
                enable <= wrDaten[STEUER_ENABLE];
            // A compare hit outranks a simultaneous write-1-to-clear.
            if (hit)
                treffer <= 1'b1;
            else if (wrSteuer && wrDaten[STEUER_TREFFER])
                treffer <= 1'b0;
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: output register, synchronised input port and timer behind a wait-state bus FSM.
// Build option: define TIMER_IRQ_EN to add the Unterbrechung output and the IRQ enable in Steuer bit2.
//
// state    | meaning
// LEERLAUF | idle; samples and latches the next request (write wins over read)
// WARTEN   | inserting the remaining LATENZ wait cycles
// QUITTUNG | one-cycle acknowledge; a latched write commits here
// FREIGABE | waits for the initiator to drop both request lines
module io_bus_responder
    import io_bus_responder_pkg::*;
#(
    parameter logic [31:0] BASIS          = 32'h0000_0100,
    parameter int          LATENZ         = 1,
    parameter int          AUSGANG_BREITE = 8,
    parameter int          EINGANG_BREITE = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    io_bus_responder_if.slave         bus,
    input  logic [EINGANG_BREITE-1:0] Eingang,
    output logic [AUSGANG_BREITE-1:0] Ausgang
`ifdef TIMER_IRQ_EN
    ,
    output logic                      Unterbrechung
`endif
);

    busState_t                 zustand;
    logic [3:0]                warteZaehler;
    logic                      istSchreiben;
    logic [31:0]               adrReg;
    logic [31:0]               datReg;
    logic [EINGANG_BREITE-1:0] eingangMeta;
    logic [EINGANG_BREITE-1:0] eingangSync;

    logic        anfrage;
    logic        starteQuittung;
    logic        quittungSchreiben;
    logic [31:0] leseAdr;
    logic [31:0] leseWert;
    logic [2:0]  schreibOfs;
    logic        schreibGueltig;
    logic        wrAusgang;
    logic        wrZaehler;
    logic        wrVergleich;
    logic        wrSteuer;

    logic [31:0] zaehler;
    logic [31:0] vergleich;
    logic        enable;
    logic        treffer;
    logic        irqEn;

    assign anfrage = bus.LesenAn | bus.SchreibenAn;

    // With LATENZ=0 the acknowledge is launched straight from the sampling edge, so
    // type and read address must come from the live bus rather than the latches.
    assign starteQuittung    = (zustand == LEERLAUF && anfrage && LATENZ == 0)
                             || (zustand == WARTEN && warteZaehler == 4'd0);
    assign quittungSchreiben = (zustand == LEERLAUF) ? bus.SchreibenAn : istSchreiben;
    assign leseAdr           = (zustand == LEERLAUF) ? bus.Adresse : adrReg;

    always_comb begin
        leseWert = '0;
        if (inWindow(leseAdr, BASIS)) begin
            case (wortOffset(leseAdr, BASIS))
                OFS_AUSGANG:   leseWert = 32'(Ausgang);
                OFS_EINGANG:   leseWert = 32'(eingangSync);
                OFS_ZAEHLER:   leseWert = zaehler;
                OFS_VERGLEICH: leseWert = vergleich;
                OFS_STEUER: begin
                    leseWert[STEUER_ENABLE]  = enable;
                    leseWert[STEUER_TREFFER] = treffer;
                    leseWert[STEUER_IRQ_EN]  = irqEn;
                end
                default:       leseWert = '0;
            endcase
        end
    end

    assign schreibGueltig = (zustand == QUITTUNG) && istSchreiben && inWindow(adrReg, BASIS);
    assign schreibOfs     = wortOffset(adrReg, BASIS);
    assign wrAusgang      = schreibGueltig && (schreibOfs == OFS_AUSGANG);
    assign wrZaehler      = schreibGueltig && (schreibOfs == OFS_ZAEHLER);
    assign wrVergleich    = schreibGueltig && (schreibOfs == OFS_VERGLEICH);
    assign wrSteuer       = schreibGueltig && (schreibOfs == OFS_STEUER);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zustand              <= LEERLAUF;
            warteZaehler         <= 4'd0;
            istSchreiben         <= 1'b0;
            adrReg               <= '0;
            datReg               <= '0;
            bus.DatenRaus        <= '0;
            bus.DatenBereit      <= 1'b0;
            bus.DatenGeschrieben <= 1'b0;
        end else begin
            bus.DatenBereit      <= 1'b0;
            bus.DatenGeschrieben <= 1'b0;
            if (starteQuittung) begin
                if (quittungSchreiben) begin
                    bus.DatenGeschrieben <= 1'b1;
                end else begin
                    bus.DatenBereit <= 1'b1;
                    bus.DatenRaus   <= leseWert;
                end
            end
            case (zustand)
                LEERLAUF: begin
                    if (anfrage) begin
                        istSchreiben <= bus.SchreibenAn;
                        adrReg       <= bus.Adresse;
                        datReg       <= bus.DatenRein;
                        if (LATENZ == 0) begin
                            zustand <= QUITTUNG;
                        end else begin
                            zustand      <= WARTEN;
                            warteZaehler <= 4'(LATENZ - 1);
                        end
                    end
                end
                WARTEN: begin
                    if (warteZaehler == 4'd0)
                        zustand <= QUITTUNG;
                    else
                        warteZaehler <= warteZaehler - 4'd1;
                end
                QUITTUNG: zustand <= FREIGABE;
                FREIGABE: begin
                    if (!anfrage)
                        zustand <= LEERLAUF;
                end
                default:  zustand <= LEERLAUF;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            eingangMeta <= '0;
            eingangSync <= '0;
            Ausgang     <= '0;
        end else begin
            eingangMeta <= Eingang;
            eingangSync <= eingangMeta;
            if (wrAusgang)
                Ausgang <= datReg[AUSGANG_BREITE-1:0];
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            irqEn         <= 1'b0;
            Unterbrechung <= 1'b0;
        end else begin
            if (wrSteuer)
                irqEn <= datReg[STEUER_IRQ_EN];
            Unterbrechung <= treffer & irqEn;
        end
    end
`else
    assign irqEn = 1'b0;
`endif

    timer_einheit u_timer (
        .Clock       (Clock),
        .Reset       (Reset),
        .wrZaehler   (wrZaehler),
        .wrVergleich (wrVergleich),
        .wrSteuer    (wrSteuer),
        .wrDaten     (datReg),
        .zaehler     (zaehler),
        .vergleich   (vergleich),
        .enable      (enable),
        .treffer     (treffer)
    );

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed and random bus accesses against a cycle-level register model.
// Optional TIMER_IRQ_EN build adds the Unterbrechung checks.
`timescale 1ns/1ps
module tb_io_bus_responder;

    localparam logic [31:0] BASIS = 32'h0000_0100;
    localparam int          LAT   = 1;
    localparam int          LAT_B = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    io_bus_responder_if busA ();
    io_bus_responder_if busB ();

    logic [7:0] eingangA, eingangB, ausgangA, ausgangB;
`ifdef TIMER_IRQ_EN
    logic irqA, irqB;
`endif

    io_bus_responder #(.BASIS(BASIS), .LATENZ(LAT)) u_dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .bus     (busA),
        .Eingang (eingangA),
        .Ausgang (ausgangA)
`ifdef TIMER_IRQ_EN
        , .Unterbrechung (irqA)
`endif
    );

    io_bus_responder #(.BASIS(BASIS), .LATENZ(LAT_B)) u_dutSlow (
        .Clock   (Clock),
        .Reset   (Reset),
        .bus     (busB),
        .Eingang (eingangB),
        .Ausgang (ausgangB)
`ifdef TIMER_IRQ_EN
        , .Unterbrechung (irqB)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference register state for DUT A, advanced once per clock from the register-map rules.
    logic [7:0]  mAus;
    logic [31:0] mZ, mV;
    logic        mEn, mTr, mIrqEn, mIrq;
    logic        wrPend;
    logic [31:0] wrAdr, wrDat, wrOfs, lastRd;

    assign wrOfs = wrAdr - BASIS;

    function automatic logic wrHit(input int o);
        return wrPend && (wrOfs == 32'(o));
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mAus <= 8'd0; mZ <= 32'd0; mV <= 32'hFFFF_FFFF;
            mEn <= 1'b0; mTr <= 1'b0; mIrqEn <= 1'b0; mIrq <= 1'b0;
        end else begin
            mAus <= wrHit(0) ? wrDat[7:0] : mAus;
            mZ   <= wrHit(2) ? wrDat : (mEn ? mZ + 32'd1 : mZ);
            mV   <= wrHit(3) ? wrDat : mV;
            mEn  <= wrHit(4) ? wrDat[0] : mEn;
            mTr  <= (mEn && mZ == mV) ? 1'b1 : ((wrHit(4) && wrDat[1]) ? 1'b0 : mTr);
`ifdef TIMER_IRQ_EN
            mIrqEn <= wrHit(4) ? wrDat[2] : mIrqEn;
`endif
            mIrq <= mTr && mIrqEn;
        end
    end

    function automatic logic [31:0] modelRead(input logic [31:0] adr, input logic [7:0] ein);
        logic [31:0] o;
        o = adr - BASIS;
        case (o)
            32'd0:   return {24'd0, mAus};
            32'd1:   return {24'd0, ein};
            32'd2:   return mZ;
            32'd3:   return mV;
            32'd4:   return {29'd0, mIrqEn, mTr, mEn};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on DUT A: latency, ack kind, read data, no double ack while held, Ausgang and held DatenRaus.
    task automatic busOp(input bit wr, input bit rd, input logic [31:0] adr,
                         input logic [31:0] dat, input int hold, input string tag);
        int c;
        bit seen;
        logic [31:0] expRd;
        @(negedge Clock);
        busA.SchreibenAn = wr;
        busA.LesenAn     = rd;
        busA.Adresse     = adr;
        busA.DatenRein   = dat;
        expRd = modelRead(adr, eingangA);
        c = 0;
        seen = 0;
        while (!seen && c < 40) begin
            if (c == LAT) expRd = modelRead(adr, eingangA);
            @(negedge Clock);
            c++;
            if (c == 1) begin
                busA.Adresse   = $urandom;
                busA.DatenRein = $urandom;
            end
            if (busA.DatenBereit || busA.DatenGeschrieben) seen = 1;
        end
        check({tag, "_latency"}, c, LAT + 1);
        check({tag, "_kind"}, {30'd0, busA.DatenGeschrieben, busA.DatenBereit}, wr ? 32'd2 : 32'd1);
        if (!wr) begin
            check({tag, "_rdata"}, busA.DatenRaus, expRd);
            lastRd = expRd;
        end else begin
            wrPend = 1'b1;
            wrAdr  = adr;
            wrDat  = dat;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge Clock);
            wrPend = 1'b0;
            check({tag, "_noDoubleAck"}, {31'd0, busA.DatenBereit | busA.DatenGeschrieben}, 32'd0);
        end
        busA.LesenAn     = 1'b0;
        busA.SchreibenAn = 1'b0;
        @(negedge Clock);
        wrPend = 1'b0;
        check({tag, "_ausgang"}, ausgangA, mAus);
        check({tag, "_rdHeld"}, busA.DatenRaus, lastRd);
    endtask

    task automatic setEingang(input logic [7:0] v);
        eingangA = v;
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nAck;
        bit seen;
        logic [31:0] x;
        busA.LesenAn = 0; busA.SchreibenAn = 0; busA.Adresse = 0; busA.DatenRein = 0;
        busB.LesenAn = 0; busB.SchreibenAn = 0; busB.Adresse = 0; busB.DatenRein = 0;
        eingangA = 0; eingangB = 0;
        wrPend = 0; wrAdr = 0; wrDat = 0; lastRd = 0;

        repeat (3) @(negedge Clock);
        check("rst_ausgang", ausgangA, 32'd0);
        check("rst_datenraus", busA.DatenRaus, 32'd0);
        check("rst_acks", {30'd0, busA.DatenGeschrieben, busA.DatenBereit}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Reset lands while the slow responder is in WARTEN: request dropped, never acknowledged.
        busB.SchreibenAn = 1; busB.Adresse = BASIS; busB.DatenRein = 32'hA5;
        @(negedge Clock);
        Reset = 1'b0;
        busB.SchreibenAn = 0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        lastRd = 0;
        nAck = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            nAck += int'(busB.DatenBereit | busB.DatenGeschrieben);
        end
        check("midrst_noAck", nAck, 0);
        check("midrst_ausgangB", ausgangB, 32'd0);
        check("midrst_datenrausB", busB.DatenRaus, 32'd0);
        check("midrst_ausgangA", ausgangA, 32'd0);

        @(negedge Clock);
        busB.SchreibenAn = 1; busB.Adresse = BASIS; busB.DatenRein = 32'h5A;
        c = 0; seen = 0;
        while (!seen && c < 40) begin
            @(negedge Clock);
            c++;
            if (busB.DatenBereit || busB.DatenGeschrieben) seen = 1;
        end
        check("slow_latency", c, LAT_B + 1);
        check("slow_kind", {30'd0, busB.DatenGeschrieben, busB.DatenBereit}, 32'd2);
        busB.SchreibenAn = 0;
        @(negedge Clock);
        check("slow_ausgang", ausgangB, 32'h5A);

        busOp(1, 0, BASIS + 0, 32'hA5, 0, "wrAusgang");
        setEingang(8'h3C);
        busOp(0, 1, BASIS + 1, 0, 0, "rdEingang");
        busOp(0, 1, BASIS + 1, 0, 5, "holdRead");
        busOp(1, 1, BASIS + 0, 32'd7, 0, "bothHigh");
        busOp(0, 1, BASIS + 40, 0, 0, "rdOutside");
        busOp(1, 0, BASIS + 50, 32'hFF, 0, "wrOutside");
        busOp(1, 0, BASIS + 6, 32'hFF, 0, "wrReserved");
        busOp(0, 1, BASIS + 6, 0, 0, "rdReserved");
        busOp(0, 1, BASIS + 3, 0, 0, "rdVergleichRst");

        // Timer: compare hit after ten increments, then clear and disable.
        busOp(1, 0, BASIS + 3, 32'd10, 0, "wrVergleich");
        busOp(1, 0, BASIS + 2, 32'd0, 0, "wrZaehler");
        busOp(1, 0, BASIS + 4, 32'd1, 0, "wrEnable");
        repeat (15) @(negedge Clock);
        busOp(0, 1, BASIS + 4, 0, 0, "rdTreffer");
        busOp(0, 1, BASIS + 2, 0, 0, "rdZaehler");
`ifdef TIMER_IRQ_EN
        busOp(1, 0, BASIS + 4, 32'd5, 0, "wrIrqEn");
        repeat (2) @(negedge Clock);
        check("irq", irqA, mIrq);
        busOp(0, 1, BASIS + 4, 0, 0, "rdSteuerIrq");
`endif
        busOp(1, 0, BASIS + 4, 32'd2, 0, "clrTreffer");
        busOp(0, 1, BASIS + 4, 0, 0, "rdCleared");
`ifdef TIMER_IRQ_EN
        check("irqCleared", irqA, mIrq);
`endif

        // Zaehler wrap from all-ones back to zero.
        busOp(1, 0, BASIS + 2, 32'hFFFF_FFFE, 0, "wrNearWrap");
        busOp(1, 0, BASIS + 4, 32'd1, 0, "enWrap");
        busOp(0, 1, BASIS + 2, 0, 0, "rdWrapped");

        // Compare hit lands on the same edge as a write-1-to-clear; the hit must survive.
        x = 32'h0000_1000;
        busOp(1, 0, BASIS + 4, 32'd2, 0, "preClr");
        busOp(1, 0, BASIS + 3, x + 32'd3, 0, "wrVglRace");
        busOp(1, 0, BASIS + 4, 32'd1, 0, "enRace");
        busOp(1, 0, BASIS + 2, x, 0, "wrZRace");
        busOp(1, 0, BASIS + 4, 32'd3, 0, "w1cRace");
        busOp(0, 1, BASIS + 4, 0, 0, "rdSetWins");
        busOp(1, 0, BASIS + 4, 32'd2, 0, "postClr");

        for (int i = 0; i < 40; i++) begin
            int op;
            logic [31:0] adr;
            op  = int'($urandom_range(0, 2));
            adr = BASIS + 32'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) adr = $urandom;
            if ($urandom_range(0, 3) == 0) setEingang(8'($urandom));
            busOp(op != 0, op != 1, adr, $urandom, int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
